// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported RAM between instruction fetch and data access.
// Optional fetch fairness is enabled by defining ARB_FETCH_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
    typedef enum logic {FETCH, DATA} ownerT;

    stateT      state, stateNext;
    ownerT      owner, ownerNext;
    logic [3:0] latCnt, latCntNext;
    logic       captureRead;
    logic       dmReq;
    logic       forceFetch;
    logic       grantFetch, grantData;

    if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1) begin : gBadParam
        $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX at least 1");
    end

    assign dmReq = dm_read | dm_write;

`ifdef ARB_FETCH_FAIRNESS_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starveCnt;

    assign forceFetch = (starveCnt == STARVE_W'(STARVE_MAX));

    // Counts data grants that overtook a waiting fetch; never passes STARVE_MAX
    // because at that value a waiting fetch always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt <= '0;
        end else if (grantFetch) begin
            starveCnt <= '0;
        end else if (grantData && if_req) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end
`else
    assign forceFetch = 1'b0;
`endif

    // Grants only exist in IDLE; gating with rst_n keeps the RAM strobe quiet
    // while reset is held, since the strobe is combinational.
    always_comb begin
        grantFetch = 1'b0;
        grantData  = 1'b0;
        if (rst_n && state == IDLE) begin
            if (dmReq && !(forceFetch && if_req)) begin
                grantData = 1'b1;
            end else if (if_req) begin
                grantFetch = 1'b1;
            end
        end
    end

    assign mem_en    = grantFetch | grantData;
    assign mem_we    = grantData & dm_write;
    assign mem_addr  = grantData ? dm_addr : (grantFetch ? if_addr : '0);
    assign mem_wdata = (grantData && dm_write) ? dm_wdata : '0;

    assign if_ack   = (state == RESP) && (owner == FETCH);
    assign dm_ack   = (state == RESP) && (owner == DATA);
    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dmReq & ~dm_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= FETCH;
            latCnt <= '0;
        end else begin
            state  <= stateNext;
            owner  <= ownerNext;
            latCnt <= latCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        ownerNext   = owner;
        latCntNext  = latCnt;
        captureRead = 1'b0;
        case (state)
            IDLE: begin
                if (grantData) begin
                    ownerNext = DATA;
                    if (dm_write) begin
                        stateNext = RESP;
                    end else begin
                        latCntNext = 4'(MEM_LAT);
                        stateNext  = WAIT;
                    end
                end else if (grantFetch) begin
                    ownerNext  = FETCH;
                    latCntNext = 4'(MEM_LAT);
                    stateNext  = WAIT;
                end
            end
            WAIT: begin
                if (latCnt <= 4'd1) begin
                    captureRead = 1'b1;
                    latCntNext  = '0;
                    stateNext   = RESP;
                end else begin
                    latCntNext = latCnt - 4'd1;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (captureRead) begin
            if (owner == FETCH) begin
                if_rdata <= mem_rdata;
            end else begin
                dm_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed timing cases plus random
// requester traffic checked against a transaction-level model with a shadow RAM.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
`ifdef ARB_FETCH_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        if_stall;
    logic        dm_read;
    logic        dm_write;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_ack;
    logic [15:0] dm_rdata;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int nCompared;
    int nMismatched;
    int cyc;

    // RAM environment: what the physical RAM holds and returns
    logic [15:0] ram [65536];
    int          rdCyc;
    logic [15:0] rdVal;

    // Reference model state
    logic [15:0] shadow [65536];
    logic        mBusy;
    logic        mOwnerFetch;
    logic        mIsWrite;
    int          mAckCyc;
    logic [15:0] mReadVal;
    logic [15:0] mIfRdata;
    logic [15:0] mDmRdata;
    int          mStarve;

    mem_port_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .dm_read  (dm_read),
        .dm_write (dm_write),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .dm_stall (dm_stall),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // RAM environment: records issued accesses, returns read data exactly
    // MEM_LAT cycles after issue and junk at every other time.
    initial begin
        rdCyc = -1;
        rdVal = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rdCyc = -1;
            end else if (mem_en && mem_we) begin
                ram[mem_addr] = mem_wdata;
            end else if (mem_en) begin
                rdCyc = cyc + MEM_LAT;
                rdVal = ram[mem_addr];
            end
        end
    end

    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdata = (cyc == rdCyc) ? rdVal : 16'($urandom);
        end
    end

    // Transaction-level model: an access occupies the port from its issue
    // cycle until its ack cycle; compare every cycle.
    initial begin : modelCompare
        logic        ackNow, expEn, expWe, expIfAck, expDmAck, forceFetch;
        logic [15:0] expAddr, expWdata;
        mBusy    = 1'b0;
        mIfRdata = '0;
        mDmRdata = '0;
        mStarve  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mBusy    = 1'b0;
                mIfRdata = '0;
                mDmRdata = '0;
                mStarve  = 0;
                checkOutput("rst_mem_en",   32'(mem_en),   32'd0);
                checkOutput("rst_mem_we",   32'(mem_we),   32'd0);
                checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
                checkOutput("rst_if_ack",   32'(if_ack),   32'd0);
                checkOutput("rst_dm_ack",   32'(dm_ack),   32'd0);
                checkOutput("rst_if_rdata", 32'(if_rdata), 32'd0);
                checkOutput("rst_dm_rdata", 32'(dm_rdata), 32'd0);
                checkOutput("rst_if_stall", 32'(if_stall), 32'(if_req));
                checkOutput("rst_dm_stall", 32'(dm_stall), 32'(dm_read | dm_write));
            end else begin
                expEn    = 1'b0;
                expWe    = 1'b0;
                expAddr  = '0;
                expWdata = '0;
                expIfAck = 1'b0;
                expDmAck = 1'b0;
                ackNow   = mBusy && (cyc == mAckCyc);
                if (ackNow) begin
                    if (mOwnerFetch) begin
                        expIfAck = 1'b1;
                        if (!mIsWrite) mIfRdata = mReadVal;
                    end else begin
                        expDmAck = 1'b1;
                        if (!mIsWrite) mDmRdata = mReadVal;
                    end
                end
                if (!mBusy) begin
                    forceFetch = FAIR && (mStarve >= STARVE_MAX) && if_req;
                    if ((dm_read || dm_write) && !forceFetch) begin
                        expEn       = 1'b1;
                        expAddr     = dm_addr;
                        mOwnerFetch = 1'b0;
                        mIsWrite    = dm_write;
                        mBusy       = 1'b1;
                        if (dm_write) begin
                            expWe            = 1'b1;
                            expWdata         = dm_wdata;
                            shadow[dm_addr]  = dm_wdata;
                            mAckCyc          = cyc + 1;
                        end else begin
                            mReadVal = shadow[dm_addr];
                            mAckCyc  = cyc + MEM_LAT + 1;
                        end
                        if (if_req) mStarve++;
                    end else if (if_req) begin
                        expEn       = 1'b1;
                        expAddr     = if_addr;
                        mOwnerFetch = 1'b1;
                        mIsWrite    = 1'b0;
                        mBusy       = 1'b1;
                        mReadVal    = shadow[if_addr];
                        mAckCyc     = cyc + MEM_LAT + 1;
                        mStarve     = 0;
                    end
                end
                checkOutput("mem_en",   32'(mem_en),   32'(expEn));
                checkOutput("mem_we",   32'(mem_we),   32'(expWe));
                if (expEn) checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
                if (expWe) checkOutput("mem_wdata", 32'(mem_wdata), 32'(expWdata));
                checkOutput("if_ack",   32'(if_ack),   32'(expIfAck));
                checkOutput("dm_ack",   32'(dm_ack),   32'(expDmAck));
                checkOutput("if_rdata", 32'(if_rdata), 32'(mIfRdata));
                checkOutput("dm_rdata", 32'(dm_rdata), 32'(mDmRdata));
                checkOutput("if_stall", 32'(if_stall), 32'(if_req & ~expIfAck));
                checkOutput("dm_stall", 32'(dm_stall), 32'((dm_read | dm_write) & ~expDmAck));
                if (ackNow) mBusy = 1'b0;
            end
        end
    end

    // Random requesters that hold each request until acked, plus rare resets.
    task automatic applyStimulus(input int nCycles);
        logic ifSeen, dmSeen;
        int   r;
        ifSeen = 1'b0;
        dmSeen = 1'b0;
        for (int i = 0; i < nCycles; i++) begin
            stepCycle();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            if (ifSeen) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 16'($urandom_range(0, 63));
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 16'($urandom_range(0, 63));
            end
            if (dmSeen || (!dm_read && !dm_write && $urandom_range(0, 2) == 0)) begin
                r        = $urandom_range(0, 4);
                dm_read  = (r == 0 || r == 2 || r == 3);
                dm_write = (r == 1 || r == 2);
                dm_addr  = 16'($urandom_range(0, 63));
                dm_wdata = 16'($urandom);
            end
            @(negedge clk);
            ifSeen = if_ack;
            dmSeen = dm_ack;
        end
    endtask

    initial begin : mainSeq
        int   ifAcks;
        logic seenDm;
        nCompared   = 0;
        nMismatched = 0;
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        for (int a = 0; a < 65536; a++) begin
            ram[a]    = 16'(a * 7) ^ 16'h3C5A;
            shadow[a] = ram[a];
        end
        ram[16'h0010] = 16'hBEEF;  shadow[16'h0010] = 16'hBEEF;
        ram[16'h0300] = 16'hCAFE;  shadow[16'h0300] = 16'hCAFE;
        ram[16'h0040] = 16'h7A7A;  shadow[16'h0040] = 16'h7A7A;

        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        stepCycle();

        // Fetch read with MEM_LAT=2
        if_req  = 1'b1;
        if_addr = 16'h0010;
        @(negedge clk);
        checkOutput("t1_mem_en",   32'(mem_en),   32'd1);
        checkOutput("t1_mem_we",   32'(mem_we),   32'd0);
        checkOutput("t1_mem_addr", 32'(mem_addr), 32'h0010);
        repeat (3) stepCycle();
        @(negedge clk);
        checkOutput("t1_if_ack",   32'(if_ack),   32'd1);
        checkOutput("t1_if_rdata", 32'(if_rdata), 32'hBEEF);
        checkOutput("t1_if_stall", 32'(if_stall), 32'd0);
        stepCycle();
        if_req = 1'b0;
        stepCycle();

        // Data write beats a pending fetch
        dm_write = 1'b1;
        dm_addr  = 16'h0200;
        dm_wdata = 16'h1234;
        if_req   = 1'b1;
        if_addr  = 16'h0030;
        @(negedge clk);
        checkOutput("t2_mem_we",    32'(mem_we),    32'd1);
        checkOutput("t2_mem_addr",  32'(mem_addr),  32'h0200);
        checkOutput("t2_mem_wdata", 32'(mem_wdata), 32'h1234);
        stepCycle();
        @(negedge clk);
        checkOutput("t2_dm_ack",   32'(dm_ack),   32'd1);
        checkOutput("t2_if_stall", 32'(if_stall), 32'd1);
        stepCycle();
        dm_write = 1'b0;
        @(negedge clk);
        checkOutput("t2_fetch_issue", 32'(mem_en & ~mem_we), 32'd1);
        checkOutput("t2_fetch_addr",  32'(mem_addr),         32'h0030);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("t2_if_stall_c4", 32'(if_stall), 32'd1);
        stepCycle();
        @(negedge clk);
        checkOutput("t2_if_ack_c5", 32'(if_ack), 32'd1);
        stepCycle();
        if_req = 1'b0;
        stepCycle();

        // Data read and fetch together
        dm_read = 1'b1;
        dm_addr = 16'h0300;
        if_req  = 1'b1;
        if_addr = 16'h0020;
        @(negedge clk);
        checkOutput("t3_mem_addr", 32'(mem_addr), 32'h0300);
        repeat (3) stepCycle();
        @(negedge clk);
        checkOutput("t3_dm_ack",   32'(dm_ack),   32'd1);
        checkOutput("t3_dm_rdata", 32'(dm_rdata), 32'hCAFE);
        stepCycle();
        dm_read = 1'b0;
        @(negedge clk);
        checkOutput("t3_fetch_addr", 32'(mem_addr), 32'h0020);
        repeat (3) stepCycle();
        @(negedge clk);
        checkOutput("t3_if_ack_c7", 32'(if_ack), 32'd1);
        stepCycle();
        if_req = 1'b0;
        stepCycle();

        // Read and write together act as a single write
        dm_read  = 1'b1;
        dm_write = 1'b1;
        dm_addr  = 16'h0400;
        dm_wdata = 16'h5555;
        @(negedge clk);
        checkOutput("t4_mem_we",    32'(mem_we),    32'd1);
        checkOutput("t4_mem_wdata", 32'(mem_wdata), 32'h5555);
        stepCycle();
        @(negedge clk);
        checkOutput("t4_dm_ack",   32'(dm_ack),   32'd1);
        checkOutput("t4_dm_rdata", 32'(dm_rdata), 32'hCAFE);
        stepCycle();
        dm_read  = 1'b0;
        dm_write = 1'b0;
        stepCycle();

        // Back-to-back data writes while fetch waits
        ifAcks   = 0;
        if_req   = 1'b1;
        if_addr  = 16'h0050;
        dm_write = 1'b1;
        dm_addr  = 16'h0500;
        dm_wdata = 16'hD000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if_ack) ifAcks++;
            if (c == 8) begin
                checkOutput("t5_mem_en_c8",   32'(mem_en),   32'd1);
                checkOutput("t5_mem_we_c8",   32'(mem_we),   FAIR ? 32'd0 : 32'd1);
                checkOutput("t5_mem_addr_c8", 32'(mem_addr), FAIR ? 32'h0050 : 32'h0504);
            end
            seenDm = dm_ack;
            stepCycle();
            if (seenDm) begin
                dm_addr  = dm_addr + 16'd1;
                dm_wdata = dm_wdata + 16'd1;
            end
        end
        checkOutput("t5_if_ack_count", 32'(ifAcks), FAIR ? 32'd1 : 32'd0);
        if_req   = 1'b0;
        dm_write = 1'b0;
        repeat (6) stepCycle();

        // Reset during a fetch read
        if_req  = 1'b1;
        if_addr = 16'h0040;
        stepCycle();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_mem_en",   32'(mem_en),   32'd0);
        checkOutput("t6_if_ack",   32'(if_ack),   32'd0);
        checkOutput("t6_if_stall", 32'(if_stall), 32'd1);
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_reissue_en",   32'(mem_en),   32'd1);
        checkOutput("t6_reissue_addr", 32'(mem_addr), 32'h0040);
        stepCycle();
        @(negedge clk);
        checkOutput("t6_no_ack_c4", 32'(if_ack), 32'd0);
        stepCycle();
        @(negedge clk);
        checkOutput("t6_no_ack_c5", 32'(if_ack), 32'd0);
        stepCycle();
        @(negedge clk);
        checkOutput("t6_if_ack_c6",   32'(if_ack),   32'd1);
        checkOutput("t6_if_rdata_c6", 32'(if_rdata), 32'h7A7A);
        stepCycle();
        if_req = 1'b0;
        stepCycle();

        applyStimulus(3000);

        stepCycle();
        rst_n    = 1'b1;
        if_req   = 1'b0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        repeat (8) stepCycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
